// File: rtl/led_status_ctrl.sv
// led_status_ctrl: debounced LED pattern from a reconfigurable partition.
// Filters led_in, freezes the display while the partition is decoupled (HOLD),
// and shows a walking one-hot pattern when the partition stops changing its
// LEDs for too long (FALLBACK). Optional PWM dimming: define LED_PWM_EN.
module led_status_ctrl #(
   parameter int STABLE_CYCLES = 16,
   parameter int TIMEOUT_BITS  = 26,
   parameter int PWM_BITS      = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          led_in,
   input  logic                pr_decouple,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [7:0]          led_out,
   output logic [1:0]          state
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_HOLD     = 2'b01,
      ST_FALLBACK = 2'b10,
      ST_BAD      = 2'b11
   } state_t;

   localparam int         PRE_BITS   = TIMEOUT_BITS - 4;
   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [7:0]              led_q, led_d;
   logic [7:0]              led_prev_q, led_prev_d;
   logic [7:0]              led_filt_q, led_filt_d;
   logic [7:0]              stab_q, stab_d;
   logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
   logic [PRE_BITS-1:0]     pre_q, pre_d;
   logic [7:0]              walk_q, walk_d;
   logic                    from_fb_q, from_fb_d;
   logic                    filt_chg_q, filt_chg_d;
   logic [7:0]              led_out_q, led_out_d;
   logic                    active;
   logic [7:0]              pattern;
   logic                    pwm_on;

   // Input capture and stability filter; counting stops (at zero) while decoupled.
   always_comb begin
      led_d      = led_in;
      led_prev_d = led_q;
      active     = !pr_decouple && (state_q == ST_RUN || state_q == ST_FALLBACK);
      stab_d     = 8'd0;
      if (active && led_q == led_prev_q)
         stab_d = (stab_q == STABLE_MAX) ? stab_q : stab_q + 8'd1;
      led_filt_d = (stab_d == STABLE_MAX) ? led_q : led_filt_q;
      filt_chg_d = (led_filt_d != led_filt_q);
   end

   // Mode FSM: decouple beats everything, a fresh filtered value beats the watchdog.
   always_comb begin
      state_d   = state_q;
      wd_d      = '0;
      pre_d     = '0;
      walk_d    = walk_q;
      from_fb_d = from_fb_q;
      case (state_q)
         ST_RUN: begin
            if (pr_decouple) begin
               state_d   = ST_HOLD;
               from_fb_d = 1'b0;
            end else if (!filt_chg_d) begin
               if (&wd_q) begin
                  state_d = ST_FALLBACK;
                  walk_d  = 8'h01;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
         end
         ST_FALLBACK: begin
            if (pr_decouple) begin
               state_d   = ST_HOLD;
               from_fb_d = 1'b1;
            end else if (filt_chg_q) begin
               state_d = ST_RUN;
            end else begin
               pre_d = pre_q + 1'b1;
               if (&pre_q) walk_d = {walk_q[6:0], walk_q[7]};
            end
         end
         ST_HOLD: if (!pr_decouple) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] bright_q, bright_d;

   // Free-running PWM counter; duty reloads only at period start so a period is never split.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      bright_d  = (&pwm_cnt_q) ? brightness : bright_q;
      pwm_on    = (pwm_cnt_q < bright_q);
   end

   // PWM state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt_q <= '0;
         bright_q  <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         bright_q  <= bright_d;
      end
   end
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign pwm_on            = 1'b1;
`endif

   // Display select: HOLD keeps showing whatever was on the LEDs when it was entered.
   always_comb begin
      pattern = led_filt_q;
      if (state_q == ST_FALLBACK || (state_q == ST_HOLD && from_fb_q))
         pattern = walk_q;
      led_out_d = pwm_on ? pattern : 8'h00;
   end

   // All control state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RUN;
         led_q      <= 8'h00;
         led_prev_q <= 8'h00;
         led_filt_q <= 8'h00;
         stab_q     <= 8'd0;
         wd_q       <= '0;
         pre_q      <= '0;
         walk_q     <= 8'h01;
         from_fb_q  <= 1'b0;
         filt_chg_q <= 1'b0;
         led_out_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         led_q      <= led_d;
         led_prev_q <= led_prev_d;
         led_filt_q <= led_filt_d;
         stab_q     <= stab_d;
         wd_q       <= wd_d;
         pre_q      <= pre_d;
         walk_q     <= walk_d;
         from_fb_q  <= from_fb_d;
         filt_chg_q <= filt_chg_d;
         led_out_q  <= led_out_d;
      end
   end

   assign led_out = led_out_q;
   assign state   = state_q;

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples of led_in required before acceptance (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 26: activity watchdog width; timeout = 2^TIMEOUT_BITS-1 cycles without accepted change.
REQ-003 SHALL have parameter PWM_BITS, default 8: width of brightness and PWM counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port led_in  input  8  LED pattern produced by the reconfigurable partition.
REQ-007 SHALL have port pr_decouple  input  1  high while the partition is being reconfigured; synchronous to clk.
REQ-008 SHALL have port brightness  input  PWM_BITS  PWM duty; sampled at each PWM period start.
REQ-009 SHALL have port led_out  output  8  registered drive to board LEDs.
REQ-010 SHALL have port state  output  2  current state: 00 RUN, 01 HOLD, 10 FALLBACK.

Function
REQ-011 SHALL register led_in into led_q every cycle (one cycle capture latency).
REQ-012 SHALL keep a saturating stability counter: cleared when led_q differs from previous led_q, else incremented.
REQ-013 SHALL load led_filt from led_q on the edge the counter reaches STABLE_CYCLES-1 with led_q unchanged; glitches shorter than STABLE_CYCLES cycles never reach led_filt.
REQ-014 SHALL, for a led_in step held steady, update led_out STABLE_CYCLES+2 edges after led_in changes (PWM disabled or duty full-on).
REQ-015 SHALL, in RUN, count cycles since the last led_filt change; a change clears the count; reaching 2^TIMEOUT_BITS-1 moves to FALLBACK on the next edge.
REQ-016 SHALL, in FALLBACK, display an internal walking one-hot pattern (bit0 first, rotating left) advancing every 2^(TIMEOUT_BITS-4) cycles; led_filt keeps tracking led_q.
REQ-017 SHALL return from FALLBACK to RUN on the edge after any led_filt change; watchdog cleared.
REQ-018 SHALL enter HOLD from any state on the edge pr_decouple is sampled high; pr_decouple has priority over watchdog timeout and filter acceptance in the same cycle.
REQ-019 SHALL, in HOLD, freeze led_filt and displayed pattern at their pre-HOLD values, hold stability and watchdog counters at zero.
REQ-020 SHALL leave HOLD for RUN on the edge pr_decouple is sampled low; filtering restarts from zero, so post-reconfiguration values need STABLE_CYCLES clean samples.
REQ-021 SHALL display led_filt in RUN and HOLD-from-RUN, walking pattern in FALLBACK and HOLD-from-FALLBACK.
REQ-022 SHALL keep the state encoding 11 unreachable; if entered, go to RUN next edge.

Reset
REQ-023 SHALL, while reset is high, force immediately: led_out=8'h00, state=RUN, led_q=led_filt=0, all counters 0, walking pattern 8'h01.
REQ-024 SHALL resume from reset values on the first edge after reset deassertion; reset mid-HOLD or mid-FALLBACK returns to RUN regardless of pr_decouple until the next sampled edge.

Configuration
REQ-025 SHALL compile a free-running PWM_BITS counter and gating when LED_PWM_EN is defined: led_out[i] = pattern[i] AND (pwm_cnt < brightness_latched); brightness 0 gives dark, all-ones gives (2^PWM_BITS-1)/2^PWM_BITS duty; brightness latched when pwm_cnt wraps to 0.
REQ-026 SHALL, without LED_PWM_EN, omit PWM logic, ignore brightness, and drive led_out = pattern registered.

Verification (bench: STABLE_CYCLES=4, TIMEOUT_BITS=6, PWM_BITS=8, LED_PWM_EN undefined unless stated)
REQ-027 SHALL cover: reset, led_in=8'hA5 held -> led_out=8'hA5 exactly 6 edges after change, state=00.
REQ-028 SHALL cover: led_in=8'h00 steady, 3-cycle pulse to 8'hFF -> led_out stays 8'h00.
REQ-029 SHALL cover: led_in constant 8'h3C for 63 cycles -> state=10 on edge 64, led_out walks 8'h01,8'h02,... every 4 cycles; then led_in=8'h0F held -> state=00, led_out=8'h0F.
REQ-030 SHALL cover: led_out=8'h5A, pr_decouple high 20 cycles while led_in toggles randomly -> state=01, led_out=8'h5A throughout; after deassert led_out updates only after 4 clean samples.
REQ-031 SHALL cover: pr_decouple rises on the watchdog-timeout edge -> state=01, not 10; reset asserted mid-HOLD -> led_out=8'h00, state=00 asynchronously.
REQ-032 SHALL cover (LED_PWM_EN defined): led_in=8'hFF, brightness=64 -> each led_out bit high exactly 64 of every 256 cycles; brightness=0 -> led_out=8'h00 constant.
